// File: rtl/demux_1_4_tdm.sv
// 1:4 TDM demultiplexer: tracks frame alignment off frame_sync and releases four
// channel samples together as one registered frame. Optional err_cnt output via DEMUX_ERR_CNT_EN.
//
// state  | meaning
// HUNT   | not aligned; waiting for a valid sample with frame_sync
// LOCKED | aligned; slot_q is the next expected slot
module demux_1_4_tdm #(
    parameter int WIDTH = 1,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] frame_data,
    output logic                 frame_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             slot_q, slot_d;
    logic [WIDTH-1:0]       shadow_q [0:NCH-2];
    logic [WIDTH-1:0]       shadow_d [0:NCH-2];
    logic [NCH*WIDTH-1:0]   frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   sync_err_q, sync_err_d;
    logic                   err_event;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        err_event     = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // An early sync aborts the partial frame and realigns on this sample.
                        err_event   = (slot_q != 2'd0);
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        err_event = 1'b1;
                        state_d   = HUNT;
                    end else if (slot_q == 2'd3) begin
                        frame_data_d  = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_valid_d = 1'b1;
                        slot_d        = 2'd0;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        sync_err_d = sync_err_q | err_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow_q      <= '{default: '0};
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: doc/demux_1_4_tdm.md
Name: demux_1_4_tdm

Overview:
Receive-side counterpart of the 4:1 mux. It takes a time-division-multiplexed sample stream (one channel per slot, slot 0 marked by a frame sync) and demultiplexes it into four parallel channel outputs. Channel outputs are registered and released together as one frame. The block tracks frame alignment, flags sync errors and re-acquires lock after an error.

Parameters:
WIDTH, 1, bits per channel sample
NCH, 4, channel count; fixed at 4, not to be overridden (slot counter is 2 bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
din  input  WIDTH  TDM sample for the current slot
din_valid  input  1  din carries a sample this cycle
frame_sync  input  1  qualifies din as slot 0 (channel 0); only meaningful with din_valid
frame_data  output  4*WIDTH  last complete frame; channel k at [WIDTH*k +: WIDTH]
frame_valid  output  1  one-cycle pulse when frame_data updates
slot  output  2  index of the next expected slot
locked  output  1  1 when aligned (LOCKED state)
sync_err  output  1  sticky error flag, cleared only by rst

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: frame_data=0, frame_valid=0, slot=0, locked=0, sync_err=0, internal shadow regs=0, state=HUNT.
- States: HUNT and LOCKED. The locked output equals (state==LOCKED).
- din_valid=0 in any state: no state change; frame_valid=0.
- HUNT:
  - din_valid & frame_sync: shadow[0]<=din, slot<=1, go to LOCKED.
  - din_valid & !frame_sync: sample discarded, stay in HUNT, slot stays 0.
- LOCKED, din_valid, slot in 1..2, !frame_sync: shadow[slot]<=din, slot<=slot+1.
- LOCKED, din_valid, slot==3, !frame_sync:
  - frame_data <= {din, shadow[2], shadow[1], shadow[0]}.
  - frame_valid=1 in the following cycle only.
  - slot wraps to 0.
- LOCKED, din_valid, slot==0, frame_sync: normal frame start; shadow[0]<=din, slot<=1.
- LOCKED, din_valid, slot==0, !frame_sync (missing sync):
  - sync_err<=1, sample discarded.
  - Go to HUNT, slot<=0.
- LOCKED, din_valid, slot!=0, frame_sync (early sync):
  - sync_err<=1, partial frame discarded; no frame_valid is issued.
  - Resync on this sample: shadow[0]<=din, slot<=1, stay LOCKED.
- Latency: frame_data and frame_valid change on the clock edge that samples slot 3. frame_valid is high for exactly one cycle. frame_data holds until the next complete frame.
- Back-to-back frames: with din_valid high every cycle, frame_valid pulses every 4th cycle.
- Gaps: din_valid gaps of any length inside a frame are tolerated with no timeout.
- frame_sync with din_valid=0 is ignored.
- Reset mid-frame: all state is cleared immediately (async); the partial frame is lost and the first frame_sync is needed to lock again.

Optional Feature:
- Macro: DEMUX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt, 8 bits, reset 0.
  - Increments once per sync_err event (missing or early sync).
  - Saturates at 255 and does not wrap.
- When undefined: port and counter are absent; sync_err behaviour is identical in both builds.

Test Plan:
- Reset then lock, WIDTH=1: rst pulse; samples 1,0,1,1 with frame_sync on the first, din_valid continuous. Expect frame_data=4'b1101, a single frame_valid pulse, locked=1, sync_err=0.
- Back-to-back frames: frames 0001, 1000, 0110 streamed continuously. Expect frame_valid on cycles 4, 8, 12 with those values, slot cycling 1,2,3,0.
- Hunt discard: before any sync, send 3 samples with frame_sync=0, then a valid frame 1010. Expect locked=0 during the first 3 samples, then frame_data=4'b1010 and sync_err=0.
- Early sync: after 2 slots, send frame_sync with din=1, then 1,1,1. Expect sync_err=1, no pulse for the aborted frame, then frame_data=4'b1111. If DEMUX_ERR_CNT_EN, expect err_cnt=1.
- Missing sync plus gaps: a complete frame, then a slot-0 sample without sync. Expect locked=0 and sync_err=1. Then send a synced frame with din_valid=0 gaps between samples; expect relock and correct frame_data.
- Async reset mid-frame: assert rst between clock edges after 2 slots. Expect all outputs 0 immediately, without waiting for a clock edge, and no frame_valid afterwards until a new synced frame completes.
